// File: rtl/gpio_bank_pkg.sv
// Shared register-map constants, the decoded bus request type and the word-count helper
// for the Wishbone GPIO bank.
package gpio_bank_pkg;

  localparam logic [7:0] GROUP_STRIDE = 8'h10;

  localparam logic [7:0] OFF_OUT    = 8'h00;
  localparam logic [7:0] OFF_OE     = 8'h10;
  localparam logic [7:0] OFF_IN     = 8'h20;
  localparam logic [7:0] OFF_RISE   = 8'h30;
  localparam logic [7:0] OFF_FALL   = 8'h40;
  localparam logic [7:0] OFF_STATUS = 8'h50;
  localparam logic [7:0] OFF_SET    = 8'h60;
  localparam logic [7:0] OFF_CLR    = 8'h70;

  typedef struct packed {
    logic        hit;
    logic        we;
    logic [7:0]  grp_off;
    logic [1:0]  word;
    logic [3:0]  sel;
    logic [31:0] dat;
  } bus_req_t;

  function automatic int words(input int pins);
    return (pins + 31) / 32;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchroniser with a previous-value register and an arm counter that
// keeps pads already high at reset from looking like rising edges.
module gpio_sync_edge
  import gpio_bank_pkg::*;
#(
  parameter int PINS = 38
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PINS-1:0] pad,
  output logic [PINS-1:0] sync,
  output logic [PINS-1:0] rise,
  output logic [PINS-1:0] fall
);

  logic [PINS-1:0] sync_p0;
  logic [PINS-1:0] sync_p1;
  logic [PINS-1:0] prev_p2;
  logic [1:0]      arm_cnt;
  logic            armed;

  assign armed = (arm_cnt == 2'd2);

  // While arming, prev is loaded from the first flop so it already matches sync when edges unmask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
      arm_cnt <= '0;
    end else begin
      sync_p0 <= pad;
      sync_p1 <= sync_p0;
      prev_p2 <= armed ? sync_p1 : sync_p0;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign sync = sync_p1;
  assign rise = armed ? (sync_p1 & ~prev_p2) : '0;
  assign fall = armed ? (~sync_p1 & prev_p2) : '0;

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank: registered pad outputs with per-pin OE, atomic set/clear,
// synchronised inputs and sticky edge status folded onto IRQ_LINES level interrupts.
module wb_gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int          PINS      = 38,
  parameter int          IRQ_LINES = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_bus_CYC,
  input  logic                 io_bus_STB,
  input  logic                 io_bus_WE,
  input  logic [3:0]           io_bus_SEL,
  input  logic [31:0]          io_bus_ADR,
  input  logic [31:0]          io_bus_DAT_MOSI,
  output logic                 io_bus_ACK,
  output logic [31:0]          io_bus_DAT_MISO,
  input  logic [PINS-1:0]      io_gpio_read,
  output logic [PINS-1:0]      io_gpio_write,
  output logic [PINS-1:0]      io_gpio_writeEnable,
  output logic [IRQ_LINES-1:0] io_irq
);

  localparam int W  = words(PINS);
  localparam int WB = W * 32;

  bus_req_t        req;
  logic            mapped;
  logic [31:0]     bmask;
  logic [31:0]     rdata;
  logic [WB-1:0]   wsel;
  logic [WB-1:0]   wdat;
  logic [WB-1:0]   rd_vec;
  logic [PINS-1:0] wsel_pins;
  logic [PINS-1:0] wdat_pins;
  logic [PINS-1:0] wr_bits;

  logic [PINS-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [PINS-1:0] out_d, oe_d, rise_en_d, fall_en_d, status_d;
  logic [PINS-1:0] clr_bits, set_ev;
  logic [PINS-1:0] sync, rise, fall;
  logic            unused_bits;

  function automatic logic [PINS-1:0] merge(input logic [PINS-1:0] cur,
                                            input logic [PINS-1:0] m,
                                            input logic [PINS-1:0] d);
    return (cur & ~m) | (d & m);
  endfunction

  function automatic logic [PINS-1:0] line_mask(input int line);
    logic [PINS-1:0] m;
    m = '0;
    for (int p = 0; p < PINS; p++)
      if (p % IRQ_LINES == line) m = m | (PINS'(1) << p);
    return m;
  endfunction

  gpio_sync_edge #(.PINS(PINS)) u_sync_edge (
    .clk  (clk),
    .reset(reset),
    .pad  (io_gpio_read),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  // ~ACK in the hit term turns a held request into a new transfer two cycles later.
  always_comb begin
    req         = '0;
    req.hit     = io_bus_CYC & io_bus_STB & ~io_bus_ACK &
                  (io_bus_ADR[31:8] == BASE_ADDR[31:8]);
    req.we      = io_bus_WE;
    req.grp_off = {io_bus_ADR[7:4], 4'h0};
    req.word    = io_bus_ADR[3:2];
    req.sel     = io_bus_SEL;
    req.dat     = io_bus_DAT_MOSI;
  end

  assign mapped = ~io_bus_ADR[7] & (int'(req.word) < W);
  assign bmask  = {{8{req.sel[3]}}, {8{req.sel[2]}}, {8{req.sel[1]}}, {8{req.sel[0]}}};

  assign wsel = (req.hit & req.we & mapped) ? (WB'(bmask) << {req.word, 5'd0}) : '0;
  assign wdat = WB'(req.dat) << {req.word, 5'd0};

  assign wsel_pins = PINS'(wsel);
  assign wdat_pins = PINS'(wdat);
  assign wr_bits   = wsel_pins & wdat_pins;

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_bits  = '0;
    case (req.grp_off)
      OFF_OUT:    out_d     = merge(out_q, wsel_pins, wdat_pins);
      OFF_OE:     oe_d      = merge(oe_q, wsel_pins, wdat_pins);
      OFF_RISE:   rise_en_d = merge(rise_en_q, wsel_pins, wdat_pins);
      OFF_FALL:   fall_en_d = merge(fall_en_q, wsel_pins, wdat_pins);
      OFF_STATUS: clr_bits  = wr_bits;
      OFF_SET:    out_d     = out_q | wr_bits;
      OFF_CLR:    out_d     = out_q & ~wr_bits;
      default:    ;
    endcase
  end

  // New events are OR-ed in after the clear so a coincident edge survives its W1C.
  assign set_ev   = (rise & rise_en_q) | (fall & fall_en_q);
  assign status_d = (status_q & ~clr_bits) | set_ev;

  always_comb begin
    rd_vec = '0;
    case (req.grp_off)
      OFF_OUT:    rd_vec = WB'(out_q);
      OFF_OE:     rd_vec = WB'(oe_q);
      OFF_IN:     rd_vec = WB'(sync);
      OFF_RISE:   rd_vec = WB'(rise_en_q);
      OFF_FALL:   rd_vec = WB'(fall_en_q);
      OFF_STATUS: rd_vec = WB'(status_q);
      default:    rd_vec = '0;
    endcase
  end

  assign rdata = mapped ? 32'(rd_vec >> {req.word, 5'd0}) : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_bus_ACK      <= 1'b0;
      io_bus_DAT_MISO <= '0;
      out_q           <= '0;
      oe_q            <= '0;
      rise_en_q       <= '0;
      fall_en_q       <= '0;
      status_q        <= '0;
    end else begin
      io_bus_ACK      <= req.hit;
      io_bus_DAT_MISO <= (req.hit && !req.we) ? rdata : 32'h0;
      out_q           <= out_d;
      oe_q            <= oe_d;
      rise_en_q       <= rise_en_d;
      fall_en_q       <= fall_en_d;
      status_q        <= status_d;
    end
  end

  assign io_gpio_write       = out_q;
  assign io_gpio_writeEnable = ~oe_q;

  for (genvar l = 0; l < IRQ_LINES; l++) begin : g_irq
    assign io_irq[l] = |(status_q & line_mask(l));
  end

  assign unused_bits = ^{io_bus_ADR[1:0], wsel, wdat};

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Randomised scoreboard bench for wb_gpio_bank against a per-pin behavioural model.
module tb_wb_gpio_bank;

  localparam int          PINS      = 38;
  localparam int          IRQ_LINES = 3;
  localparam int          W         = 2;
  localparam logic [31:0] BASE      = 32'h3000_0000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]           sel = 4'h0;
  logic [31:0]          adr = '0, mosi = '0;
  logic                 ack;
  logic [31:0]          miso;
  logic [PINS-1:0]      pads = '0;
  logic [PINS-1:0]      gw, gwe;
  logic [IRQ_LINES-1:0] irq;

  always #5 clk = ~clk;

  wb_gpio_bank #(.PINS(PINS), .IRQ_LINES(IRQ_LINES), .BASE_ADDR(BASE)) dut (
    .clk                (clk),
    .reset              (reset),
    .io_bus_CYC         (cyc),
    .io_bus_STB         (stb),
    .io_bus_WE          (we),
    .io_bus_SEL         (sel),
    .io_bus_ADR         (adr),
    .io_bus_DAT_MOSI    (mosi),
    .io_bus_ACK         (ack),
    .io_bus_DAT_MISO    (miso),
    .io_gpio_read       (pads),
    .io_gpio_write      (gw),
    .io_gpio_writeEnable(gwe),
    .io_irq             (irq)
  );

  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  bit out_m[PINS], oe_m[PINS], re_m[PINS], fe_m[PINS], st_m[PINS], pad_m[PINS];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ACK consumes one expected read word.
  always @(negedge clk) begin
    if (reset && ack) begin
      if (exp_q.size() == 0) check("unexpected_ack", 1, 0);
      else check("rd_data", miso, exp_q.pop_front());
    end else if (reset) begin
      check("miso_idle", miso, 0);
    end
  end

  function automatic void model_reset();
    for (int p = 0; p < PINS; p++) begin
      out_m[p] = 0; oe_m[p] = 0; re_m[p] = 0; fe_m[p] = 0; st_m[p] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input int off);
    int g, w, p;
    logic [31:0] r;
    g = off / 16;
    w = (off / 4) % 4;
    r = '0;
    if (g > 7 || w >= W) return r;
    for (int b = 0; b < 32; b++) begin
      p = w * 32 + b;
      if (p < PINS)
        case (g)
          0: r[b] = out_m[p];
          1: r[b] = oe_m[p];
          2: r[b] = pad_m[p];
          3: r[b] = re_m[p];
          4: r[b] = fe_m[p];
          5: r[b] = st_m[p];
          default: r[b] = 1'b0;
        endcase
    end
    return r;
  endfunction

  function automatic void model_write(input int off, input logic [3:0] s, input logic [31:0] d);
    int g, w, p;
    g = off / 16;
    w = (off / 4) % 4;
    if (g > 7 || w >= W) return;
    for (int b = 0; b < 32; b++) begin
      p = w * 32 + b;
      if (p < PINS && s[b/8])
        case (g)
          0: out_m[p] = d[b];
          1: oe_m[p]  = d[b];
          3: re_m[p]  = d[b];
          4: fe_m[p]  = d[b];
          5: if (d[b]) st_m[p] = 0;
          6: if (d[b]) out_m[p] = 1;
          7: if (d[b]) out_m[p] = 0;
          default: ;
        endcase
    end
  endfunction

  function automatic void model_pads(input logic [PINS-1:0] nv);
    for (int p = 0; p < PINS; p++) begin
      if (!pad_m[p] && nv[p] && re_m[p]) st_m[p] = 1;
      if (pad_m[p] && !nv[p] && fe_m[p]) st_m[p] = 1;
      pad_m[p] = nv[p];
    end
  endfunction

  function automatic logic [IRQ_LINES-1:0] model_irq();
    logic [IRQ_LINES-1:0] r;
    r = '0;
    for (int p = 0; p < PINS; p++)
      if (st_m[p]) r = r | (IRQ_LINES'(1) << (p % IRQ_LINES));
    return r;
  endfunction

  task automatic check_pads();
    logic [PINS-1:0] e_out, e_oen;
    for (int p = 0; p < PINS; p++) begin
      e_out[p] = out_m[p];
      e_oen[p] = !oe_m[p];
    end
    check("gpio_write", gw, e_out);
    check("gpio_oe_n", gwe, e_oen);
    check("irq", irq, model_irq());
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_rd);
    bit got;
    got = 0;
    if (exp_ack) exp_q.push_back(w ? 32'h0 : exp_rd);
    adr = a; we = w; sel = s; mosi = d; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got && exp_ack) void'(exp_q.pop_back());
    check("ack_seen", got, exp_ack);
  endtask

  task automatic wr(input int off, input logic [3:0] s, input logic [31:0] d);
    bus(BASE + off, 1'b1, s, d, 1'b1, 32'h0);
    model_write(off, s, d);
  endtask

  task automatic rd(input int off);
    bus(BASE + off, 1'b0, 4'hF, 32'h0, 1'b1, model_read(off));
  endtask

  task automatic drive_pads(input logic [PINS-1:0] nv);
    pads = nv;
    repeat (4) @(posedge clk);
    #1;
    model_pads(nv);
    check("irq_after_pads", irq, model_irq());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PINS-1:0] nv;
    logic [63:0]     r64;
    int              kind, g, w;

    model_reset();
    r64 = {$urandom, $urandom};
    pads = r64[PINS-1:0];
    repeat (3) @(posedge clk);
    #1;
    check("ack_in_reset", ack, 0);
    reset = 1'b1;
    for (int p = 0; p < PINS; p++) pad_m[p] = pads[p];
    repeat (4) @(posedge clk);
    #1;
    check_pads();
    for (int off = 0; off <= 'h74; off += 4) rd(off);

    // OE, atomic set and clear
    wr('h10, 4'hF, 32'h0000_00FF);
    wr('h60, 4'hF, 32'h0000_0005);
    wr('h70, 4'hF, 32'h0000_0001);
    check("oe_n_low_byte", gwe[7:0], 8'h00);
    check("out_low_byte", gw[7:0], 8'h04);
    check_pads();
    bus(BASE + 'h00, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0004);

    // byte select, unmapped and out-of-window addresses
    wr('h70, 4'hF, 32'hFFFF_FFFF);
    wr('h00, 4'b0010, 32'hFFFF_FFFF);
    bus(BASE + 'h00, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_FF00);
    bus(BASE + 'hF0, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
    bus(BASE + 'hF0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0);
    bus(BASE + 'h100, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
    check_pads();

    // rising edge on pin 33 with latency checks
    drive_pads('0);
    wr('h34, 4'hF, 32'h0000_0002);
    nv = '0;
    nv[33] = 1'b1;
    pads = nv;
    @(posedge clk); #1;
    check("irq0_k", irq[0], 0);
    @(posedge clk); #1;
    check("irq0_k1", irq[0], 0);
    @(posedge clk); #1;
    check("irq0_k2", irq[0], 1);
    repeat (2) @(posedge clk);
    #1;
    model_pads(nv);
    bus(BASE + 'h54, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0002);
    rd('h24);
    wr('h54, 4'hF, 32'h0000_0002);
    check("irq0_cleared", irq[0], 0);
    check_pads();

    // fall event on pin 4 coinciding with its W1C
    wr('h40, 4'hF, 32'h0000_0010);
    drive_pads(pads | 38'h10);
    drive_pads(pads & ~38'h10);
    drive_pads(pads | 38'h10);
    rd('h50);
    nv = pads & ~38'h10;
    pads = nv;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus(BASE + 'h50, 1'b1, 4'hF, 32'h0000_0010, 1'b1, 32'h0);
    model_write('h50, 4'hF, 32'h0000_0010);
    model_pads(nv);
    bus(BASE + 'h50, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0010);
    check("irq1_race", irq[1], 1);

    // randomised mix of writes, reads and pad activity
    for (int i = 0; i < 160; i++) begin
      kind = $urandom_range(0, 9);
      g = $urandom_range(0, 8);
      w = $urandom_range(0, 3);
      if (kind < 4) begin
        wr(g * 16 + w * 4, 4'($urandom), $urandom);
        check_pads();
      end else if (kind < 8) begin
        rd(g * 16 + w * 4);
      end else begin
        r64 = {$urandom, $urandom} & {$urandom, $urandom};
        drive_pads(pads ^ r64[PINS-1:0]);
      end
    end

    // reset during the ACK cycle, pads held high across it
    wr('h30, 4'hF, 32'hFFFF_FFFF);
    wr('h34, 4'hF, 32'hFFFF_FFFF);
    drive_pads('1);
    adr = BASE; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("ack_before_reset", ack, 1);
    cyc = 1'b0; stb = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("ack_async_drop", ack, 0);
    check("miso_async_drop", miso, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    wr('h30, 4'hF, 32'hFFFF_FFFF);
    wr('h34, 4'hF, 32'hFFFF_FFFF);
    repeat (6) @(posedge clk);
    #1;
    bus(BASE + 'h50, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0);
    bus(BASE + 'h54, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0);
    rd('h20);
    rd('h24);
    check_pads();

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
